// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared FIFO helpers: pointer/count width functions and the status bundle
// reused by the single-clock and dual-clock FIFOs.
// ----------------------------------------------------------------------------
package fifo_pkg;

  // Binary pointer width; never below 1 bit so a depth-1 corner still elaborates.
  function automatic int ptr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// ----------------------------------------------------------------------------
// sync_fifo_ram
// Single-clock simple dual-port storage array for sync_fifo.
// Write port is registered. The read port is registered in standard mode and
// a combinational lookahead when SYNC_FIFO_FWFT_EN is defined (the prefetch
// register then lives in sync_fifo).
//
// Ports:
//   clk      in   clock
//   reset    in   sync active-high, clears the read register (standard only)
//   rd_en    in   load read register from rd_addr (standard only)
//   wr_en    in   write wr_data to wr_addr
//   wr_addr  in   PW-bit write address
//   wr_data  in   BITSIZE-bit write data
//   rd_addr  in   PW-bit read address
//   rd_data  out  BITSIZE-bit read data
// ----------------------------------------------------------------------------
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int  BITSIZE = 8,
  parameter int  MEMSIZE = 32,
  localparam int PW      = ptr_width(MEMSIZE)
) (
  input  logic               clk,
`ifndef SYNC_FIFO_FWFT_EN
  input  logic               reset,
  input  logic               rd_en,
`endif
  input  logic               wr_en,
  input  logic [PW-1:0]      wr_addr,
  input  logic [BITSIZE-1:0] wr_data,
  input  logic [PW-1:0]      rd_addr,
  output logic [BITSIZE-1:0] rd_data
);

  logic [BITSIZE-1:0] mem [MEMSIZE];

  // NOTE: storage has no reset; only the pointers and count define what is
  // valid, and an unreset array maps onto plain RAM cells. Sequential state
  // uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data = mem[rd_addr];
`else
  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
`endif

endmodule

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO of any depth >= 2 with occupancy count, programmable
// almost-full/almost-empty flags and sticky overflow/underflow flags.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through reads.
//
// Ports:
//   clk           in   clock, all state updates on the rising edge
//   reset         in   synchronous active-high, overrides every other input
//   w_enable      in   write request
//   wdata         in   BITSIZE write data
//   r_enable      in   read request
//   clear_err     in   clears overflow/underflow
//   rdata         out  BITSIZE read data
//   rvalid        out  rdata holds a valid word
//   full          out  count == MEMSIZE
//   empty         out  no word is readable
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  CNTW words held (includes the FWFT output word)
//   overflow      out  sticky: write attempted while full
//   underflow     out  sticky: read attempted while empty
// ----------------------------------------------------------------------------
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int  BITSIZE  = 8,
  parameter int  MEMSIZE  = 32,
  parameter int  AF_LEVEL = MEMSIZE - 2,
  parameter int  AE_LEVEL = 2,
  localparam int CNTW     = cnt_width(MEMSIZE),
  localparam int PW       = ptr_width(MEMSIZE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               w_enable,
  input  logic [BITSIZE-1:0] wdata,
  input  logic               r_enable,
  input  logic               clear_err,
  output logic [BITSIZE-1:0] rdata,
  output logic               rvalid,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [CNTW-1:0]    count,
  output logic               overflow,
  output logic               underflow
);

  localparam fifo_status_t STATUS_RST = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                                          almost_empty: 1'b1, overflow: 1'b0,
                                          underflow: 1'b0};

  fifo_status_t       st_q, st_d;
  logic [CNTW-1:0]    count_d;
  logic [PW-1:0]      wptr, rptr, wptr_d, rptr_d;
  logic               wr_acc, rd_acc, rd_adv;
  logic [BITSIZE-1:0] ram_rdata;

`ifdef SYNC_FIFO_FWFT_EN
  logic               load, out_valid_d;
  logic [BITSIZE-1:0] out_reg;
`else
  logic               rvalid_q;
`endif

  // Pointers wrap at MEMSIZE-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MEMSIZE - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    wr_acc  = w_enable & ~st_q.full  & ~reset;
    rd_acc  = r_enable & ~st_q.empty & ~reset;
    count_d = count + CNTW'(wr_acc) - CNTW'(rd_acc);
    st_d    = st_q;
    rd_adv  = rd_acc;

`ifdef SYNC_FIFO_FWFT_EN
    // The output register holds the head; refill it from the array when it is
    // empty or being popped, using only words already committed to the array.
    load        = (st_q.empty | rd_acc) & (count != CNTW'(!st_q.empty)) & ~reset;
    out_valid_d = load | (~st_q.empty & ~rd_acc);
    rd_adv      = load;
    st_d.empty  = ~out_valid_d;
`else
    st_d.empty  = (count_d == '0);
`endif

    wptr_d = wr_acc ? ptr_inc(wptr) : wptr;
    rptr_d = rd_adv ? ptr_inc(rptr) : rptr;

    st_d.full         = (count_d == CNTW'(MEMSIZE));
    st_d.almost_full  = (count_d >= CNTW'(AF_LEVEL));
    st_d.almost_empty = (count_d <= CNTW'(AE_LEVEL));
    // A set condition wins over clear_err in the same cycle.
    st_d.overflow     = (st_q.overflow  & ~clear_err) | (w_enable & st_q.full);
    st_d.underflow    = (st_q.underflow & ~clear_err) | (r_enable & st_q.empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= STATUS_RST;
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      st_q  <= st_d;
      count <= count_d;
      wptr  <= wptr_d;
      rptr  <= rptr_d;
    end
  end

  sync_fifo_ram #(
    .BITSIZE (BITSIZE),
    .MEMSIZE (MEMSIZE)
  ) u_ram (
    .clk     (clk),
`ifndef SYNC_FIFO_FWFT_EN
    .reset   (reset),
    .rd_en   (rd_acc),
`endif
    .wr_en   (wr_acc),
    .wr_addr (wptr),
    .wr_data (wdata),
    .rd_addr (rptr),
    .rd_data (ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  always_ff @(posedge clk) begin
    if (reset)     out_reg <= '0;
    else if (load) out_reg <= ram_rdata;
  end

  assign rdata  = out_reg;
  assign rvalid = ~st_q.empty;
`else
  always_ff @(posedge clk) begin
    if (reset) rvalid_q <= 1'b0;
    else       rvalid_q <= rd_acc;
  end

  assign rdata  = ram_rdata;
  assign rvalid = rvalid_q;
`endif

  assign full         = st_q.full;
  assign empty        = st_q.empty;
  assign almost_full  = st_q.almost_full;
  assign almost_empty = st_q.almost_empty;
  assign overflow     = st_q.overflow;
  assign underflow    = st_q.underflow;

endmodule
